// File: rtl/mdu_pkg.sv
// mdu_pkg: shared M-extension opcodes, unit FSM states, divider iteration counts and opcode helpers
package mdu_pkg;
  typedef enum logic [4:0] {
    ALU_MUL    = 5'b01111,
    ALU_MULH   = 5'b10000,
    ALU_MULHSU = 5'b10001,
    ALU_MULHU  = 5'b10010,
    ALU_DIV    = 5'b10011,
    ALU_DIVU   = 5'b10100,
    ALU_REM    = 5'b10101,
    ALU_REMU   = 5'b10110,
    ALU_MULW   = 5'b10111,
    ALU_DIVW   = 5'b11000,
    ALU_DIVUW  = 5'b11001,
    ALU_REMW   = 5'b11010,
    ALU_REMUW  = 5'b11011
  } alu_ctrl_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_e;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;
  function automatic logic is_mdu(input logic [4:0] op);
    return op >= ALU_MUL && op <= ALU_REMUW;
  endfunction
  function automatic logic is_mul(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};
  endfunction
  function automatic logic is_word(input logic [4:0] op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction
  function automatic logic is_sdiv(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction
  function automatic logic is_rem(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction
  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction
  function automatic logic [63:0] div_ext(input logic [63:0] x, input logic [4:0] op);
    return is_word(op) ? {{32{is_sdiv(op) & x[31]}}, x[31:0]} : x;
  endfunction
  function automatic logic [63:0] div_mag(input logic [63:0] x, input logic [4:0] op);
    logic [63:0] e;
    e = div_ext(x, op);
    return (is_sdiv(op) & e[63]) ? -e : e;
  endfunction
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned radix-2 restoring divider, one quotient bit per cycle, outputs show the post-iteration values
module mdu_divider (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_start,
  input  logic        i_word,
  input  logic [63:0] i_dividend,
  input  logic [63:0] i_divisor,
  output logic [63:0] o_quotient,
  output logic [63:0] o_remainder,
  output logic        o_last
);
  import mdu_pkg::*;
  logic [63:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_n, quo_n;
  logic [64:0] t, diff;
  logic [6:0]  cnt_q, cnt_d;
  always_comb begin
    t     = {rem_q, quo_q[63]};
    diff  = t - {1'b0, dvs_q};
    rem_n = diff[64] ? t[63:0] : diff[63:0];
    quo_n = {quo_q[62:0], ~diff[64]};
    rem_d = i_start ? '0 : (cnt_q != '0) ? rem_n : rem_q;
    quo_d = i_start ? (i_word ? {i_dividend[31:0], 32'b0} : i_dividend) : (cnt_q != '0) ? quo_n : quo_q;
    dvs_d = i_start ? i_divisor : dvs_q;
    cnt_d = i_start ? (i_word ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64)) : cnt_q - 7'(cnt_q != '0);
  end
  always_ff @(posedge i_clk or negedge i_arst)
    if (!i_arst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  assign o_quotient  = quo_n;
  assign o_remainder = rem_n;
  assign o_last      = cnt_q == 7'd1;
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle RV64M multiply/divide unit with start/done handshake and flush
module mdu_unit #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_arst,
  input  logic            i_valid,
  input  logic [4:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_1,
  input  logic [XLEN-1:0] i_src_2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  import mdu_pkg::*;
  mdu_state_e  state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [63:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [63:0] a_ext, b_ext, q, r, div_raw, div_res, mul_res, dv_quo, dv_rem;
  logic [127:0] ma, mb, prod;
  logic        word, sdiv, a_neg, b_neg, div_zero, div_ovf, div_end, accept, dv_start, dv_last;
  always_comb begin
    word     = is_word(op_q);
    sdiv     = is_sdiv(op_q);
    a_ext    = div_ext(a_q, op_q);
    b_ext    = div_ext(b_q, op_q);
    a_neg    = sdiv & a_ext[63];
    b_neg    = sdiv & b_ext[63];
    div_zero = b_ext == '0;
    div_ovf  = sdiv & (a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) & (b_ext == '1);
    div_end  = div_zero | div_ovf | dv_last;
    q        = (a_neg ^ b_neg) ? -dv_quo : dv_quo;
    r        = a_neg ? -dv_rem : dv_rem;
    div_raw  = div_zero ? (is_rem(op_q) ? a_ext : '1) : div_ovf ? (is_rem(op_q) ? '0 : a_ext) : (is_rem(op_q) ? r : q);
    div_res  = word ? sext32(div_raw[31:0]) : div_raw;
    ma       = {{64{(op_q == ALU_MULH || op_q == ALU_MULHSU) & a_q[63]}}, a_q};
    mb       = {{64{(op_q == ALU_MULH) & b_q[63]}}, b_q};
    prod     = ma * mb;
    mul_res  = op_q == ALU_MUL ? prod[63:0] : op_q == ALU_MULW ? sext32(prod[31:0]) : prod[127:64];
    accept   = i_valid & (state_q == S_IDLE) & ~i_flush & is_mdu(i_alu_control);
    dv_start = accept & ~is_mul(i_alu_control);
    op_d     = accept ? i_alu_control : op_q;
    a_d      = accept ? i_src_1 : a_q;
    b_d      = accept ? i_src_2 : b_q;
    state_d  = i_flush ? S_IDLE :
               state_q == S_IDLE ? (accept ? (is_mul(i_alu_control) ? S_MUL : S_DIV) : S_IDLE) :
               state_q == S_MUL  ? S_DONE :
               state_q == S_DIV  ? (div_end ? S_DONE : S_DIV) : S_IDLE;
    result_d = (i_flush || state_d != S_DONE) ? result_q : state_q == S_MUL ? mul_res : div_res;
  end
  mdu_divider u_div (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_start    (dv_start),
    .i_word     (is_word(i_alu_control)),
    .i_dividend (div_mag(i_src_1, i_alu_control)),
    .i_divisor  (div_mag(i_src_2, i_alu_control)),
    .o_quotient (dv_quo),
    .o_remainder(dv_rem),
    .o_last     (dv_last)
  );
  always_ff @(posedge i_clk or negedge i_arst)
    if (!i_arst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  assign o_ready  = state_q == S_IDLE;
  assign o_busy   = ~o_ready;
  assign o_done   = state_q == S_DONE;
  assign o_result = result_q;
endmodule
